// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise gate unit: eight 2-input gate functions applied per bit,
// with results buffered in a 2-entry output queue plus reduction flags and a pop counter.

// Single-bit gate slice; the top replicates it across WIDTH bits.
module logic_unit_lane (
    input  logic       a,
    input  logic       b,
    input  logic [2:0] op,
    output logic       y
);
    always_comb begin
        y = 1'b0;
        unique case (op)
            3'd0: y = a & b;
            3'd1: y = ~(a & b);
            3'd2: y = a | b;
            3'd3: y = ~(a | b);
            3'd4: y = a ^ b;
            3'd5: y = ~(a ^ b);
            3'd6: y = ~a;
            3'd7: y = ~b;
            default: y = 1'b0;
        endcase
    end
endmodule

module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [2:0]       y_op,
    output logic             red_and,
    output logic             red_or,
    output logic             red_xor,
    output logic [CNT_W-1:0] done_cnt
);
    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [2:0]       op;
    } entry_t;

    logic [WIDTH-1:0] gate_y;
    entry_t           new_ent;

    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic             accept, pop;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic_unit_lane u_lane (
            .a  (a[i]),
            .b  (b[i]),
            .op (op),
            .y  (gate_y[i])
        );
    end

    assign new_ent   = '{y: gate_y, op: op};
    assign in_ready  = !rst && (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head slot is the visible entry; it is left untouched when the last entry
    // pops so the outputs keep showing the most recently popped result.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        done_cnt_d = done_cnt_q;
        if (pop) begin
            done_cnt_d = done_cnt_q + CNT_W'(1);
        end
        unique case ({accept, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = new_ent;
                else                 tail_d = new_ent;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) head_d = tail_q;
                count_d = count_q - 2'd1;
            end
            // Accept and pop together only occurs with count=1 (full blocks accept).
            2'b11: head_d = new_ent;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 2'd0;
            done_cnt_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign y        = head_q.y;
    assign y_op     = head_q.op;
    assign red_and  = &head_q.y;
    assign red_or   = |head_q.y;
    assign red_xor  = ^head_q.y;
    assign done_cnt = done_cnt_q;
endmodule
